// File: rtl/proc_clk_pkg.sv
// Shared definitions for the phase enable generator.
//   state_t    : control FSM encoding (IDLE / RUN / STEP / DRAIN)
//   MIN_PHASES : smallest supported NUM_PHASES
//   MAX_PHASES : largest supported NUM_PHASES
package proc_clk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam int MIN_PHASES = 2;
  localparam int MAX_PHASES = 16;

endpackage

// File: rtl/phase_counter.sv
// Phase datapath: per-phase cycle counter, phase index and latched divide.
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset
//   clear     : hold counters at zero (controller idle)
//   advance   : count this cycle (busy and not stalled)
//   div       : cycles per phase minus one
//   tick      : current phase ends this cycle
//   last      : phase_idx is the final phase of the round
//   phase_idx : current phase index
module phase_counter #(
  parameter int NUM_PHASES = 4,
  parameter int DIV_W      = 4,
  parameter int IDX_W      = $clog2(NUM_PHASES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  logic [DIV_W-1:0] div,
  output logic             tick,
  output logic             last,
  output logic [IDX_W-1:0] phase_idx
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;

  assign tick = advance && (cnt == div_q);
  assign last = (phase_idx == LAST_IDX);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt       <= '0;
      phase_idx <= '0;
      div_q     <= '0;
    end else begin
      // div_q is captured on the edge that leads into a round start
      // (idle, or wrapping out of the last phase) so the value is already
      // in force on the round's first cycle, where a div of 0 must tick.
      // It is frozen for the rest of the round.
      if (clear || (tick && last))
        div_q <= div;
      if (clear) begin
        cnt       <= '0;
        phase_idx <= '0;
      end else if (tick) begin
        cnt       <= '0;
        phase_idx <= last ? '0 : phase_idx + 1'b1;
      end else if (advance) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/phase_enable_gen.sv
// Phase enable generator: emits one one-hot enable pulse at the end of each
// of NUM_PHASES phases per round, each phase lasting div+1 cycles.
//   clock      : rising-edge clock
//   reset      : synchronous active-high reset
//   run        : level, free-running rounds while high
//   step       : pulse, one round when idle
//   stall      : level, freezes everything and masks enables
//   div        : cycles per phase minus one (sampled at round start)
//   phase_en   : one-hot pulse, bit k at the end of phase k
//   phase_idx  : current phase index
//   round_done : pulse with the last phase enable
//   busy       : controller is in RUN, STEP or DRAIN
module phase_enable_gen
  import proc_clk_pkg::*;
#(
  parameter int NUM_PHASES = 4,
  parameter int DIV_W      = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          run,
  input  logic                          step,
  input  logic                          stall,
  input  logic [DIV_W-1:0]              div,
  output logic [NUM_PHASES-1:0]         phase_en,
  output logic [$clog2(NUM_PHASES)-1:0] phase_idx,
  output logic                          round_done,
  output logic                          busy
);

  localparam int IDX_W = $clog2(NUM_PHASES);

  if (NUM_PHASES < MIN_PHASES || NUM_PHASES > MAX_PHASES) begin : g_bad_phases
    $error("phase_enable_gen: NUM_PHASES out of range");
  end

  state_t state, state_nxt;
  logic   tick, last;

  phase_counter #(
    .NUM_PHASES(NUM_PHASES),
    .DIV_W     (DIV_W),
    .IDX_W     (IDX_W)
  ) u_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear    (state == ST_IDLE),
    .advance  (busy && !stall),
    .div      (div),
    .tick     (tick),
    .last     (last),
    .phase_idx(phase_idx)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Stall freezes the controller along with the counters.
  always_comb begin
    state_nxt = state;
    if (!stall) begin
      unique case (state)
        ST_IDLE:  if (run) state_nxt = ST_RUN;
                  else if (step) state_nxt = ST_STEP;
        ST_RUN:   if (!run) state_nxt = ST_DRAIN;
        ST_STEP,
        ST_DRAIN: if (tick && last) state_nxt = ST_IDLE;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // tick already includes the stall mask, so enables vanish under stall.
  always_comb begin
    busy       = (state != ST_IDLE);
    round_done = tick && last;
    phase_en   = '0;
    if (tick) phase_en[phase_idx] = 1'b1;
  end

endmodule

// File: tb/tb_phase_enable_gen.sv
module tb_phase_enable_gen;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run   = 1'b0;
  logic       step  = 1'b0;
  logic       stall = 1'b0;
  logic [3:0] div   = 4'd0;
  logic [3:0] phase_en;
  logic [1:0] phase_idx;
  logic       round_done;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int         c;
    logic [3:0] en;
    logic       rd;
  } ev_t;

  ev_t exp_q[$];

  phase_enable_gen #(.NUM_PHASES(4), .DIV_W(4)) dut (
    .clock     (clock),
    .reset     (reset),
    .run       (run),
    .step      (step),
    .stall     (stall),
    .div       (div),
    .phase_en  (phase_en),
    .phase_idx (phase_idx),
    .round_done(round_done),
    .busy      (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
    end
  endtask

  // Expected enable for phase k in cycle c; round_done with the last phase.
  task automatic push(input int c, input int k);
    ev_t e;
    logic [3:0] one;
    one  = 4'b0001;
    e.c  = c;
    e.en = one << k;
    e.rd = (k == 3);
    exp_q.push_back(e);
  endtask

  // Advance to cycle c, ending 1 time unit after its opening edge.
  task automatic go(input int c);
    while (cyc < c) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Scoreboard: every observed enable must match the next expected event.
  always @(negedge clock) begin
    if (phase_en != 4'd0 || round_done) begin
      chk("onehot", int'($onehot(phase_en)), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_en", int'(phase_en), 0);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        chk("en_cycle", cyc, e.c);
        chk("en_value", int'(phase_en), int'(e.en));
        chk("round_done", int'(round_done), int'(e.rd));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t;
    // Reset state
    go(2);
    chk("rst_phase_en", int'(phase_en), 0);
    chk("rst_round_done", int'(round_done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_phase_idx", int'(phase_idx), 0);
    reset = 1'b0;
    go(4);

    // div=0 free run, two rounds, then drain
    div = 4'd0; run = 1'b1; t = cyc;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) push(t + 1 + 4*r + k, k);
    go(t + 2);
    chk("a_idx", int'(phase_idx), 1);
    chk("a_busy", int'(busy), 1);
    go(t + 6); run = 1'b0;
    go(t + 9);
    chk("a_idle_busy", int'(busy), 0);
    chk("a_idle_idx", int'(phase_idx), 0);
    go(t + 11);

    // div=2 latency, run dropped after phase 1
    div = 4'd2; run = 1'b1; t = cyc;
    push(t + 3, 0); push(t + 6, 1); push(t + 9, 2); push(t + 12, 3);
    go(t + 7); run = 1'b0;
    go(t + 12);
    chk("b_busy_last", int'(busy), 1);
    go(t + 13);
    chk("b_idle_busy", int'(busy), 0);
    go(t + 15);

    // single step, div=1; second step mid-round ignored
    div = 4'd1; step = 1'b1; t = cyc;
    for (int k = 0; k < 4; k++) push(t + 2 + 2*k, k);
    go(t + 1); step = 1'b0;
    chk("c_busy", int'(busy), 1);
    go(t + 3); step = 1'b1;
    go(t + 4); step = 1'b0;
    go(t + 9);
    chk("c_idle_busy", int'(busy), 0);
    go(t + 14);
    chk("c_still_idle", int'(busy), 0);

    // stall 5 cycles with cnt=1, div=3
    div = 4'd3; run = 1'b1; t = cyc;
    push(t + 9, 0); push(t + 13, 1); push(t + 17, 2); push(t + 21, 3);
    go(t + 2); stall = 1'b1;
    go(t + 4);
    chk("d_stall_en", int'(phase_en), 0);
    chk("d_stall_idx", int'(phase_idx), 0);
    chk("d_stall_busy", int'(busy), 1);
    go(t + 7); stall = 1'b0;
    go(t + 10); run = 1'b0;
    go(t + 22);
    chk("d_idle_busy", int'(busy), 0);
    go(t + 24);

    // div change mid-round, then reset (with stall) during phase 2
    div = 4'd1; run = 1'b1; t = cyc;
    for (int k = 0; k < 4; k++) push(t + 2 + 2*k, k);
    push(t + 12, 0); push(t + 16, 1);
    go(t + 3); div = 4'd3;
    go(t + 18);
    chk("e_idx_phase2", int'(phase_idx), 2);
    reset = 1'b1; stall = 1'b1;
    go(t + 19);
    chk("e_rst_en", int'(phase_en), 0);
    chk("e_rst_rd", int'(round_done), 0);
    chk("e_rst_busy", int'(busy), 0);
    chk("e_rst_idx", int'(phase_idx), 0);
    run = 1'b0; reset = 1'b0; stall = 1'b0; div = 4'd0;
    go(t + 26);

    // run and step together in idle: run wins
    div = 4'd0; run = 1'b1; step = 1'b1; t = cyc;
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) push(t + 1 + 4*r + k, k);
    go(t + 1); step = 1'b0;
    go(t + 5); run = 1'b0;
    go(t + 9);
    chk("f_idle_busy", int'(busy), 0);
    go(t + 12);

    chk("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/phase_enable_gen.md
PHASE_ENABLE_GEN -- requirements
Module: phase_enable_gen

Interface
REQ-001 SHALL have parameter NUM_PHASES, default 4, number of phase enables per round (legal 2..16).
REQ-002 SHALL have parameter DIV_W, default 4, width of the per-phase divide value.
REQ-003 SHALL have port clock  input  1  sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port run  input  1  level; 1 = free-running rounds.
REQ-006 SHALL have port step  input  1  one-cycle pulse; requests exactly one round while idle.
REQ-007 SHALL have port stall  input  1  level; freezes counters and suppresses enables.
REQ-008 SHALL have port div  input  DIV_W  cycles per phase minus one.
REQ-009 SHALL have port phase_en  output  NUM_PHASES  one-hot enable pulse, bit k = end of phase k.
REQ-010 SHALL have port phase_idx  output  clog2(NUM_PHASES)  current phase index.
REQ-011 SHALL have port round_done  output  1  pulse coincident with phase_en[NUM_PHASES-1].
REQ-012 SHALL have port busy  output  1  high in RUN, STEP and DRAIN states.

Function
REQ-013 SHALL implement states IDLE, RUN, STEP, DRAIN.
REQ-014 IDLE: run=1 -> RUN; else step=1 -> STEP; else remain; counters held at zero.
REQ-015 RUN: run=0 -> DRAIN (round in progress continues).
REQ-016 STEP and DRAIN SHALL return to IDLE in the cycle after round_done; run/step ignored meanwhile.
REQ-017 Phase cycle counter cnt SHALL start at 0 on first non-IDLE cycle; tick when cnt==div_q, then cnt<=0 and phase_idx<=phase_idx+1, wrapping NUM_PHASES-1 -> 0.
REQ-018 phase_en[phase_idx] SHALL be 1 for exactly the tick cycle; all other bits 0; never more than one bit set.
REQ-019 div SHALL be sampled into div_q only when phase_idx==0 and cnt==0 (round start); mid-round div changes take effect next round.
REQ-020 div=0 SHALL give a tick every non-stalled cycle.
REQ-021 Latency: run rising in cycle t -> first phase_en[0] in cycle t+1+div (no stall).
REQ-022 stall=1 SHALL hold cnt, phase_idx, state and force phase_en=0 and round_done=0; resumes exactly where held.
REQ-023 stall and a pending tick in same cycle: stall wins; tick occurs in first unstalled cycle.
REQ-024 step while busy SHALL be ignored (not queued).
REQ-025 run and step simultaneous in IDLE: run wins.

Reset
REQ-026 reset=1 SHALL force state IDLE, cnt=0, phase_idx=0, div_q=0, phase_en=0, round_done=0, busy=0 next edge, overriding stall, run, step.
REQ-027 reset asserted mid-round SHALL abandon the round with no further enables.

Structure
REQ-028 State enum and legal-range constants SHALL live in shared package proc_clk_pkg.
REQ-029 The cnt/phase_idx/div_q datapath SHALL be one sub-module, phase_counter; FSM stays in top.
REQ-030 Outputs SHALL be registered or derived only from registered state plus stall.

Verification
REQ-031 Reset, run=1, div=0, NUM_PHASES=4 -> phase_en 0001,0010,0100,1000 in cycles t+1..t+4; round_done at t+4; repeats.
REQ-032 div=2, run=1 at t -> phase_en[0] at t+3, [1] at t+6, [3] and round_done at t+12.
REQ-033 run=1 then run=0 after phase_en[1] -> phases 2,3 still emitted, IDLE and busy=0 cycle after round_done.
REQ-034 step pulse in IDLE, div=1 -> exactly 4 enables over 8 cycles, then IDLE; second step during round ignored.
REQ-035 stall=1 for 5 cycles with cnt=1, div=3 -> no enables for 5 cycles, next tick 2 cycles after stall drops.
REQ-036 div changed 1->3 mid-round, then reset in phase 2 -> old spacing kept to round end, new spacing next round; after reset all outputs 0, phase_idx=0.
